// File: rtl/pulse_gen_multi_if.sv
// ---------------------------------------------------------------------------
// pulse_gen_multi_if
// Bundles the request-side and pulse-side signals of the multi-channel pulse
// generator so that the generator and whoever drives it share one port.
//
// Signals:
//   signal_in  [N_CH]   per-channel input to watch for edges
//   hold       [N_CH]   per-channel request to keep the pulse asserted
//   mode       [2]      shared edge select (rise/fall/both/level)
//   pulse_len  [CNT_W]  shared pulse width in cycles (0 behaves as 1)
//   pulse_out  [N_CH]   per-channel pulse
//   busy       [N_CH]   channel is stretching or holding a pulse
//   any_pulse  [1]      OR of all pulse_out bits
//
// Modports:
//   master  drives the requests, observes the pulses
//   slave   the pulse generator itself
// ---------------------------------------------------------------------------
interface pulse_gen_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4
);
  logic [N_CH-1:0]  signal_in;
  logic [N_CH-1:0]  hold;
  logic [1:0]       mode;
  logic [CNT_W-1:0] pulse_len;
  logic [N_CH-1:0]  pulse_out;
  logic [N_CH-1:0]  busy;
  logic             any_pulse;

  modport master (
    output signal_in, hold, mode, pulse_len,
    input  pulse_out, busy, any_pulse
  );

  modport slave (
    input  signal_in, hold, mode, pulse_len,
    output pulse_out, busy, any_pulse
  );
endinterface

// File: rtl/pulse_gen_multi.sv
// ---------------------------------------------------------------------------
// pulse_gen_multi
// N_CH independent edge-triggered pulse generators sharing one mode and one
// pulse length. Each channel either produces a pulse of max(pulse_len,1)
// cycles (retriggerable, no gap) or, while its hold request is present,
// keeps the pulse up as long as the input stays at the level captured when
// it fired. The edge cycle itself is answered combinationally.
//
// Ports:
//   clk     rising-edge clock for all state
//   rst     asynchronous active-high reset; also masks pulse_out while high
//   bus_if  pulse_gen_multi_if.slave (signal_in, hold, mode, pulse_len in;
//           pulse_out, busy, any_pulse out)
//
// Parameters:
//   N_CH         number of channels (>= 1)
//   CNT_W        width of pulse_len and of each channel's down-counter
//   SYNC_STAGES  flops in front of signal_in and hold (0 = use raw inputs)
// ---------------------------------------------------------------------------
module pulse_gen_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 0
) (
  input  logic               clk,
  input  logic               rst,
  pulse_gen_multi_if.slave   bus_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HELD  = 2'd2
  } state_t;

  logic [N_CH-1:0]  sig;
  logic [N_CH-1:0]  hld;
  logic [N_CH-1:0]  prev_q;
  logic [N_CH-1:0]  lvl_q;
  logic [N_CH-1:0]  lvl_d;
  logic [N_CH-1:0]  edgeDet;
  logic [N_CH-1:0]  pulseRaw;
  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic             levelMode;
  logic             lenLong;
  logic [CNT_W-1:0] cntLoad;

  // Optional input delay line. With zero stages the raw inputs are used so
  // that the edge is seen in the very cycle it arrives.
  generate
    if (SYNC_STAGES == 0) begin : gNoSync
      assign sig = bus_if.signal_in;
      assign hld = bus_if.hold;
    end else begin : gSync
      logic [N_CH-1:0] sigPipe_q [SYNC_STAGES];
      logic [N_CH-1:0] hldPipe_q [SYNC_STAGES];

      // Shift both request vectors through SYNC_STAGES flops; the last
      // stage feeds the edge detectors.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < SYNC_STAGES; s++) begin
            sigPipe_q[s] <= '0;
            hldPipe_q[s] <= '0;
          end
        end else begin
          sigPipe_q[0] <= bus_if.signal_in;
          hldPipe_q[0] <= bus_if.hold;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            sigPipe_q[s] <= sigPipe_q[s-1];
            hldPipe_q[s] <= hldPipe_q[s-1];
          end
        end
      end

      assign sig = sigPipe_q[SYNC_STAGES-1];
      assign hld = hldPipe_q[SYNC_STAGES-1];
    end
  endgenerate

  assign levelMode = (bus_if.mode == 2'b11);
  assign lenLong   = (bus_if.pulse_len > CNT_W'(1));
  assign cntLoad   = bus_if.pulse_len - CNT_W'(2);

  // Edge select shared by all channels. Level mode never reports an edge
  // because the FSM is bypassed there.
  always_comb begin
    edgeDet = '0;
    case (bus_if.mode)
      2'b00:   edgeDet = sig & ~prev_q;
      2'b01:   edgeDet = ~sig & prev_q;
      2'b10:   edgeDet = sig ^ prev_q;
      default: edgeDet = '0;
    endcase
  end

  // Per-channel next state and raw pulse. The counter holds the number of
  // PULSE cycles still to come after the current one, so a load of len-2 at
  // the edge cycle gives exactly len cycles overall. The captured level is
  // simply the post-edge input value, which is 1 for rising and 0 for
  // falling and the new value in both-edge mode.
  always_comb begin
    pulseRaw = '0;
    lvl_d    = lvl_q;
    for (int ch = 0; ch < N_CH; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      if (levelMode) begin
        state_d[ch]  = IDLE;
        pulseRaw[ch] = sig[ch];
      end else begin
        case (state_q[ch])
          IDLE: begin
            pulseRaw[ch] = edgeDet[ch];
            if (edgeDet[ch]) begin
              if (hld[ch]) begin
                state_d[ch] = HELD;
                lvl_d[ch]   = sig[ch];
              end else if (lenLong) begin
                state_d[ch] = PULSE;
                cnt_d[ch]   = cntLoad;
              end
            end
          end
          PULSE: begin
            pulseRaw[ch] = 1'b1;
            if (edgeDet[ch] && hld[ch]) begin
              state_d[ch] = HELD;
              lvl_d[ch]   = sig[ch];
            end else if (edgeDet[ch]) begin
              if (lenLong) begin
                cnt_d[ch] = cntLoad;
              end else begin
                state_d[ch] = IDLE;
              end
            end else if (cnt_q[ch] == '0) begin
              state_d[ch] = IDLE;
            end else begin
              cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
            end
          end
          HELD: begin
            pulseRaw[ch] = hld[ch] & (sig[ch] == lvl_q[ch]);
            if (!hld[ch] || (sig[ch] != lvl_q[ch])) begin
              state_d[ch] = IDLE;
            end
          end
          default: begin
            state_d[ch] = IDLE;
          end
        endcase
      end
    end
  end

  // Channel state registers. prev always tracks the (delayed) input so
  // that a channel released from reset with its input high sees a rising
  // edge on the first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      lvl_q  <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        state_q[ch] <= IDLE;
        cnt_q[ch]   <= '0;
      end
    end else begin
      prev_q <= sig;
      lvl_q  <= lvl_d;
      for (int ch = 0; ch < N_CH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
    end
  end

  // Outputs. The pulse is masked during reset because with no input flops
  // a high input would otherwise look like an edge against prev = 0.
  always_comb begin
    bus_if.busy = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      bus_if.busy[ch] = (state_q[ch] != IDLE);
    end
    bus_if.pulse_out = rst ? '0 : pulseRaw;
    bus_if.any_pulse = |bus_if.pulse_out;
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_pulse_gen_multi
// Directed bench for pulse_gen_multi. One instance with no input flops and
// one with two input flops. Each step drives the inputs just after a rising
// clock edge, pushes the expected pulse/busy vectors for that cycle to a
// queue, and the values are popped and compared at the following falling
// edge.
// ---------------------------------------------------------------------------
module tb_pulse_gen_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 4;

  typedef struct {
    string      tag;
    logic       sel;
    logic [3:0] pulse;
    logic [3:0] busy;
  } exp_t;

  logic clk;
  logic rst;
  int   passCnt;
  int   totalCnt;
  int   cycle;
  exp_t expQ[$];

  pulse_gen_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus  ();
  pulse_gen_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus2 ();

  pulse_gen_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  pulse_gen_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dutSync (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus2)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the selected instance.
  task automatic checkOutput();
    exp_t       e;
    logic [3:0] obsPulse;
    logic [3:0] obsBusy;
    logic       obsAny;
    totalCnt++;
    assert (expQ.size() != 0) passCnt++;
    else $error("[TB] FAIL scoreboard_empty cycle=%0d observed=0 expected=1", cycle);
    if (expQ.size() != 0) begin
      e        = expQ.pop_front();
      obsPulse = e.sel ? bus2.pulse_out : bus.pulse_out;
      obsBusy  = e.sel ? bus2.busy      : bus.busy;
      obsAny   = e.sel ? bus2.any_pulse : bus.any_pulse;
      totalCnt++;
      assert (obsPulse === e.pulse) passCnt++;
      else $error("[TB] FAIL %s.pulse_out cycle=%0d observed=%b expected=%b", e.tag, cycle, obsPulse, e.pulse);
      totalCnt++;
      assert (obsBusy === e.busy) passCnt++;
      else $error("[TB] FAIL %s.busy cycle=%0d observed=%b expected=%b", e.tag, cycle, obsBusy, e.busy);
      totalCnt++;
      assert (obsAny === (|e.pulse)) passCnt++;
      else $error("[TB] FAIL %s.any_pulse cycle=%0d observed=%b expected=%b", e.tag, cycle, obsAny, |e.pulse);
    end
  endtask

  // One clock cycle: drive inputs, record what this cycle must show, check
  // it at the falling edge, then move to just after the next rising edge.
  task automatic applyStimulus(input logic sel, input logic rstVal,
                               input logic [3:0] sigVal, input logic [3:0] holdVal,
                               input logic [3:0] expPulse, input logic [3:0] expBusy,
                               input string tag);
    exp_t e;
    rst = rstVal;
    if (sel) begin
      bus2.signal_in = sigVal;
      bus2.hold      = holdVal;
    end else begin
      bus.signal_in = sigVal;
      bus.hold      = holdVal;
    end
    e.tag   = tag;
    e.sel   = sel;
    e.pulse = expPulse;
    e.busy  = expBusy;
    expQ.push_back(e);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Directed sequence.
  initial begin
    logic [3:0] r;
    logic [3:0] h;
    passCnt        = 0;
    totalCnt       = 0;
    cycle          = 0;
    rst            = 1'b1;
    bus.signal_in  = '0;
    bus.hold       = '0;
    bus.mode       = 2'b00;
    bus.pulse_len  = 4'd3;
    bus2.signal_in = '0;
    bus2.hold      = '0;
    bus2.mode      = 2'b00;
    bus2.pulse_len = 4'd1;
    @(posedge clk);
    #1;

    // Reset: outputs masked even with a high input.
    applyStimulus(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "reset_gate");
    applyStimulus(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "reset_state");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "post_reset");

    // Rising edge, len 3, input stays high.
    applyStimulus(0, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "rise_len3");
    applyStimulus(0, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, "rise_len3");
    applyStimulus(0, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, "rise_len3");
    applyStimulus(0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "rise_len3_end");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "rise_fall_ignored");

    // Both-edge retrigger, len 4: high from the first edge through 5 more cycles.
    bus.mode      = 2'b10;
    bus.pulse_len = 4'd4;
    applyStimulus(0, 0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, "retrig");
    applyStimulus(0, 0, 4'b0010, 4'b0000, 4'b0010, 4'b0010, "retrig");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0010, "retrig_edge");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0010, "retrig_tail");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "retrig_end");

    // Hold released first.
    bus.mode      = 2'b00;
    bus.pulse_len = 4'd2;
    applyStimulus(0, 0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, "hold_edge");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, "hold_on");
    applyStimulus(0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, "hold_drop");
    applyStimulus(0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, "hold_idle");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "hold_sig_low");

    // Hold with the input leaving the captured level first.
    applyStimulus(0, 0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, "hold2_edge");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, "hold2_on");
    applyStimulus(0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0100, "hold2_sig_drop");
    applyStimulus(0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, "hold2_idle");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "hold2_release");

    // Falling edge with len 0 gives a single cycle.
    bus.mode      = 2'b01;
    bus.pulse_len = 4'd0;
    applyStimulus(0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, "fall_rise_ignored");
    applyStimulus(0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, "fall_high");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b1000, 4'b0000, "fall_edge");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "fall_one_cycle");

    // Level pass-through: hold and length have no effect.
    bus.mode      = 2'b11;
    bus.pulse_len = 4'd7;
    for (int i = 0; i < 8; i++) begin
      r = 4'($urandom_range(0, 15));
      h = 4'($urandom_range(0, 15));
      applyStimulus(0, 0, r, h, r, 4'b0000, "level");
    end
    applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "level_clear");

    // Reset in the middle of an 8-cycle pulse, then a fresh pulse.
    bus.mode      = 2'b00;
    bus.pulse_len = 4'd8;
    applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "rst_pre");
    applyStimulus(0, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "rst_pulse");
    applyStimulus(0, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, "rst_pulse");
    applyStimulus(0, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, "rst_pulse");
    applyStimulus(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "rst_mid");
    applyStimulus(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "rst_mid");
    applyStimulus(0, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, "rst_release_edge");
    for (int i = 0; i < 7; i++)
      applyStimulus(0, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, "rst_fresh");
    applyStimulus(0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "rst_fresh_end");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "rst_fresh_low");

    // Two input flops: all channels edge together, pulse shows two cycles later.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "sync_quiet");
    applyStimulus(1, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "sync_edge_in");
    applyStimulus(1, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "sync_stage1");
    applyStimulus(1, 0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, "sync_pulse");
    applyStimulus(1, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "sync_after");
    applyStimulus(1, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "sync_after");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
